// File: rtl/retry_controller_pkg.sv
// Shared types and elaboration helpers for the retry controller slice.
package retry_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RSP = 3'd2,
    BACKOFF  = 3'd3,
    REPORT   = 3'd4,
    FAILED   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OK                = 2'd0,
    EXHAUSTED_ERR     = 2'd1,
    CRITICAL          = 2'd2,
    EXHAUSTED_TIMEOUT = 2'd3
  } status_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Backoff before retry k, where prev_retries = k-1.
  function automatic int unsigned backoff_cycles(input int unsigned base,
                                                 input int unsigned prev_retries,
                                                 input int unsigned max_shift);
    return base << ((prev_retries < max_shift) ? prev_retries : max_shift);
  endfunction

endpackage

// File: rtl/retry_controller_if.sv
// Bundles the upstream, downstream, response, completion and status signals.
interface retry_controller_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_RETRIES = 3
);
  localparam int unsigned RCW = $clog2(MAX_RETRIES + 1);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  rsp_valid;
  logic                  rsp_error;
  logic                  rsp_critical;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  r_valid;
  logic                  r_ready;
  logic [1:0]            r_status;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  clear_fail;
  logic [2:0]            recovery_state;
  logic [RCW-1:0]        retry_count;
  logic [15:0]           total_retries;

  modport slave (
    input  s_valid, s_data, m_ready, rsp_valid, rsp_error, rsp_critical, rsp_data,
           r_ready, clear_fail,
    output s_ready, m_valid, m_data, r_valid, r_status, r_data,
           recovery_state, retry_count, total_retries
  );

  modport master (
    output s_valid, s_data, m_ready, rsp_valid, rsp_error, rsp_critical, rsp_data,
           r_ready, clear_fail,
    input  s_ready, m_valid, m_data, r_valid, r_status, r_data,
           recovery_state, retry_count, total_retries
  );
endinterface

// File: rtl/retry_controller_timer.sv
// Loadable down-counter shared by the response timeout and the retry backoff.
module retry_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/retry_controller.sv
// Single-outstanding request issuer with timeout watchdog, capped exponential
// backoff retries, one status completion per request and a sticky FAILED state.
module retry_controller
  import retry_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned MAX_RETRIES       = 3,
  parameter int unsigned BACKOFF_BASE      = 4,
  parameter int unsigned BACKOFF_MAX_SHIFT = 3,
  parameter int unsigned TIMEOUT_CYCLES    = 64
) (
  input logic               clk,
  input logic               rst_n,
  retry_controller_if.slave bus
);
  localparam int unsigned RCW    = $clog2(MAX_RETRIES + 1);
  localparam int unsigned BO_MAX = BACKOFF_BASE << BACKOFF_MAX_SHIFT;
  localparam int unsigned TW     = $clog2(max_u(TIMEOUT_CYCLES, BO_MAX) + 1);

  if ((MAX_RETRIES == 0) || (BACKOFF_BASE == 0) || (TIMEOUT_CYCLES == 0)) begin : g_bad_params
    $error("retry_controller: MAX_RETRIES, BACKOFF_BASE and TIMEOUT_CYCLES must be nonzero");
  end

  state_t                state_q, state_d;
  status_t               status_q, status_d;
  logic [DATA_WIDTH-1:0] req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RCW-1:0]        rc_q, rc_d;
  logic [15:0]           total_q, total_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_dec;
  logic          tmr_zero;
  logic          fail;
  logic          fail_tmo;

  retry_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    rc_d     = rc_q;
    total_d  = total_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    fail     = 1'b0;
    fail_tmo = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          req_d   = bus.s_data;
          rc_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
          state_d  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response in the timer's last cycle takes priority over the timeout.
        if (bus.rsp_valid && bus.rsp_critical) begin
          status_d = CRITICAL;
          rdata_d  = req_q;
          state_d  = REPORT;
        end else if (bus.rsp_valid && !bus.rsp_error) begin
          status_d = OK;
          rdata_d  = bus.rsp_data;
          state_d  = REPORT;
        end else if (bus.rsp_valid) begin
          fail = 1'b1;
        end else if (tmr_zero) begin
          fail     = 1'b1;
          fail_tmo = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end

        if (fail) begin
          if (rc_q < RCW'(MAX_RETRIES)) begin
            rc_d     = rc_q + 1'b1;
            total_d  = (total_q == 16'hFFFF) ? total_q : total_q + 16'd1;
            tmr_load = 1'b1;
            tmr_val  = TW'(backoff_cycles(BACKOFF_BASE, int'(rc_q), BACKOFF_MAX_SHIFT) - 1);
            state_d  = BACKOFF;
          end else begin
            status_d = fail_tmo ? EXHAUSTED_TIMEOUT : EXHAUSTED_ERR;
            rdata_d  = req_q;
            state_d  = REPORT;
          end
        end
      end
      BACKOFF: begin
        if (tmr_zero) begin
          state_d = ISSUE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      REPORT: begin
        if (bus.r_ready) begin
          state_d = (status_q == CRITICAL) ? FAILED : IDLE;
        end
      end
      FAILED: begin
        if (bus.clear_fail) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= OK;
      req_q    <= '0;
      rdata_q  <= '0;
      rc_q     <= '0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      rc_q     <= rc_d;
      total_q  <= total_d;
    end
  end

  assign bus.s_ready        = (state_q == IDLE);
  assign bus.m_valid        = (state_q == ISSUE);
  assign bus.m_data         = req_q;
  assign bus.r_valid        = (state_q == REPORT);
  assign bus.r_status       = status_q;
  assign bus.r_data         = rdata_q;
  assign bus.recovery_state = state_q;
  assign bus.retry_count    = rc_q;
  assign bus.total_retries  = total_q;
endmodule

// File: tb/tb_retry_controller.sv
// Directed bench: instance A (timeout 16) covers pass/retry/timeout/critical/stall/reset,
// instance B (5 retries, shift cap 1) covers the backoff cap.
module tb_retry_controller;
  logic clk;
  logic rst_n;
  logic sel;
  logic [2:0] mon_state;

  int checks;
  int passes;
  int issues, cyc, nbo, run, n;
  int bo[8];
  logic stable;

  retry_controller_if #(.DATA_WIDTH(32), .MAX_RETRIES(3)) ia ();
  retry_controller_if #(.DATA_WIDTH(32), .MAX_RETRIES(5)) ib ();

  retry_controller #(
    .DATA_WIDTH(32), .MAX_RETRIES(3), .BACKOFF_BASE(4),
    .BACKOFF_MAX_SHIFT(3), .TIMEOUT_CYCLES(16)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

  retry_controller #(
    .DATA_WIDTH(32), .MAX_RETRIES(5), .BACKOFF_BASE(4),
    .BACKOFF_MAX_SHIFT(1), .TIMEOUT_CYCLES(16)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  assign mon_state = sel ? ib.recovery_state : ia.recovery_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept_a(input logic [31:0] d);
    ia.s_valid = 1'b1;
    ia.s_data  = d;
    step();
    ia.s_valid = 1'b0;
  endtask

  task automatic rsp_a(input logic err, input logic crit, input logic [31:0] d);
    ia.rsp_valid    = 1'b1;
    ia.rsp_error    = err;
    ia.rsp_critical = crit;
    ia.rsp_data     = d;
    step();
    ia.rsp_valid    = 1'b0;
    ia.rsp_error    = 1'b0;
    ia.rsp_critical = 1'b0;
  endtask

  // Counts consecutive BACKOFF cycles starting now; ends in the reissue cycle.
  task automatic backoff_len();
    n = 0;
    while (mon_state == 3'd3 && n < 100) begin
      n++;
      step();
    end
  endtask

  // Runs from the first ISSUE cycle to REPORT, recording issues and backoff runs.
  task automatic run_to_report();
    issues = 0; cyc = 0; nbo = 0; run = 0;
    for (int i = 0; i < 8; i++) bo[i] = 0;
    while (mon_state != 3'd4 && cyc < 2000) begin
      if (mon_state == 3'd1) issues++;
      if (mon_state == 3'd3) run++;
      else if (run > 0) begin
        if (nbo < 8) bo[nbo] = run;
        nbo++;
        run = 0;
      end
      step();
      cyc++;
    end
  endtask

  initial begin
    checks = 0; passes = 0; sel = 1'b0;
    rst_n = 1'b0;
    ia.s_valid = 0; ia.s_data = '0; ia.m_ready = 1; ia.rsp_valid = 0; ia.rsp_error = 0;
    ia.rsp_critical = 0; ia.rsp_data = '0; ia.r_ready = 1; ia.clear_fail = 0;
    ib.s_valid = 0; ib.s_data = '0; ib.m_ready = 1; ib.rsp_valid = 1; ib.rsp_error = 1;
    ib.rsp_critical = 0; ib.rsp_data = 32'h0000DEAD; ib.r_ready = 1; ib.clear_fail = 0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_s_ready", ia.s_ready, 1);
    chk("rst_m_valid", ia.m_valid, 0);
    chk("rst_r_valid", ia.r_valid, 0);
    chk("rst_r_status", ia.r_status, 0);
    chk("rst_m_data", ia.m_data, 0);
    chk("rst_r_data", ia.r_data, 0);
    chk("rst_state", ia.recovery_state, 0);
    chk("rst_retry", ia.retry_count, 0);
    chk("rst_total", ia.total_retries, 0);

    // Clean pass
    accept_a(32'hABCD1234);
    chk("pass_m_valid", ia.m_valid, 1);
    chk("pass_m_data", ia.m_data, 32'hABCD1234);
    chk("pass_s_ready", ia.s_ready, 0);
    step();
    chk("pass_wait", ia.recovery_state, 2);
    rsp_a(1'b0, 1'b0, 32'h0000BEEF);
    chk("pass_r_valid", ia.r_valid, 1);
    chk("pass_r_status", ia.r_status, 0);
    chk("pass_r_data", ia.r_data, 32'h0000BEEF);
    chk("pass_retry", ia.retry_count, 0);
    step();
    chk("pass_idle", ia.recovery_state, 0);

    // Two errors then OK
    accept_a(32'h11112222);
    step();
    rsp_a(1'b1, 1'b0, 32'h0);
    backoff_len();
    chk("err_bo1", n, 4);
    chk("err_reissue1", ia.m_valid, 1);
    step();
    rsp_a(1'b1, 1'b0, 32'h0);
    backoff_len();
    chk("err_bo2", n, 8);
    chk("err_reissue2", ia.m_valid, 1);
    step();
    rsp_a(1'b0, 1'b0, 32'h00C0FFEE);
    chk("err_r_status", ia.r_status, 0);
    chk("err_r_data", ia.r_data, 32'h00C0FFEE);
    chk("err_retry", ia.retry_count, 2);
    chk("err_total", ia.total_retries, 2);
    step();

    // Exhaustion by timeout: 4 x (ISSUE + 16 WAIT) + 4 + 8 + 16 backoff = 96 cycles
    accept_a(32'h5A5A0001);
    run_to_report();
    chk("tmo_in_report", mon_state, 4);
    chk("tmo_cycles", cyc, 96);
    chk("tmo_issues", issues, 4);
    chk("tmo_nbo", nbo, 3);
    chk("tmo_bo0", bo[0], 4);
    chk("tmo_bo1", bo[1], 8);
    chk("tmo_bo2", bo[2], 16);
    chk("tmo_r_status", ia.r_status, 3);
    chk("tmo_r_data", ia.r_data, 32'h5A5A0001);
    chk("tmo_retry", ia.retry_count, 3);
    chk("tmo_total", ia.total_retries, 5);
    step();
    chk("tmo_idle", ia.recovery_state, 0);

    // Backoff cap on instance B: 6 x (ISSUE + WAIT) + 4 + 8*4 = 48 cycles
    sel = 1'b1;
    ib.s_valid = 1'b1;
    ib.s_data  = 32'h0BADF00D;
    step();
    ib.s_valid = 1'b0;
    run_to_report();
    chk("cap_in_report", mon_state, 4);
    chk("cap_cycles", cyc, 48);
    chk("cap_issues", issues, 6);
    chk("cap_nbo", nbo, 5);
    chk("cap_bo0", bo[0], 4);
    chk("cap_bo1", bo[1], 8);
    chk("cap_bo2", bo[2], 8);
    chk("cap_bo3", bo[3], 8);
    chk("cap_bo4", bo[4], 8);
    chk("cap_r_status", ib.r_status, 1);
    chk("cap_r_data", ib.r_data, 32'h0BADF00D);
    chk("cap_retry", ib.retry_count, 5);
    step();
    chk("cap_idle", ib.recovery_state, 0);
    sel = 1'b0;

    // Critical dominates error, no retry, sticky FAILED
    accept_a(32'hC0DE0002);
    step();
    rsp_a(1'b1, 1'b1, 32'h12121212);
    chk("crit_r_valid", ia.r_valid, 1);
    chk("crit_r_status", ia.r_status, 2);
    chk("crit_r_data", ia.r_data, 32'hC0DE0002);
    chk("crit_retry", ia.retry_count, 0);
    chk("crit_total", ia.total_retries, 5);
    step();
    chk("crit_failed", ia.recovery_state, 5);
    chk("crit_s_ready", ia.s_ready, 0);
    chk("crit_m_valid", ia.m_valid, 0);
    ia.s_valid = 1'b1;
    ia.s_data  = 32'hFFFF0000;
    step();
    ia.s_valid = 1'b0;
    chk("crit_sticky", ia.recovery_state, 5);
    ia.clear_fail = 1'b1;
    step();
    ia.clear_fail = 1'b0;
    chk("crit_cleared", ia.recovery_state, 0);
    chk("crit_cleared_s_ready", ia.s_ready, 1);

    // Backpressure on issue and completion
    ia.m_ready = 1'b0;
    accept_a(32'h12345678);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(ia.m_valid === 1'b1 && ia.m_data === 32'h12345678)) stable = 1'b0;
      step();
    end
    chk("bp_m_stable", stable, 1);
    chk("bp_m_still_issue", ia.recovery_state, 1);
    ia.m_ready = 1'b1;
    step();
    ia.r_ready = 1'b0;
    rsp_a(1'b0, 1'b0, 32'h0000CAFE);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(ia.r_valid === 1'b1 && ia.r_status === 2'd0 && ia.r_data === 32'h0000CAFE))
        stable = 1'b0;
      step();
    end
    chk("bp_r_stable", stable, 1);
    ia.r_ready = 1'b1;
    step();
    chk("bp_idle", ia.recovery_state, 0);

    // Reset during BACKOFF drops the request
    accept_a(32'h55555555);
    step();
    rsp_a(1'b1, 1'b0, 32'h0);
    step();
    chk("rr_in_backoff", ia.recovery_state, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_state", ia.recovery_state, 0);
    chk("rr_m_valid", ia.m_valid, 0);
    chk("rr_m_data", ia.m_data, 0);
    chk("rr_r_valid", ia.r_valid, 0);
    chk("rr_retry", ia.retry_count, 0);
    chk("rr_total", ia.total_retries, 0);
    step(); step();
    rst_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ia.r_valid !== 1'b0 || ia.m_valid !== 1'b0 || ia.s_ready !== 1'b1) stable = 1'b0;
    end
    chk("rr_no_completion", stable, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
